// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry ripples through one CHUNK-bit slice per
// register stage, with overflow/zero flags and a globally stalled valid/ready pipeline.
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int MSB    = WIDTH - 1;

   // Handshake: a transfer happens on a rising edge where valid && ready. The whole pipe
   // advances when the output register is empty or being drained, so in_ready follows
   // out_ready combinationally; while stalled every stage and output holds its value.
   logic en;

   assign en       = ~g_st[STAGES-1].v_q | out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * CHUNK;

      logic               v_i;
      logic               c_i;
      logic [WIDTH-1:LO]  a_i;
      logic [WIDTH-1:LO]  b_i;
      logic [CHUNK:0]     slice;
      logic [LO+CHUNK-1:0] s_n;
      logic               v_q;
      logic               c_q;
      logic [LO+CHUNK-1:0] s_q;

      // Stage 0 conditions the operands; later stages take the unconsumed upper slices
      if (k == 0) begin : g_in
         assign v_i = in_valid;
         assign a_i = a;
         assign b_i = sub ? ~b : b;
         assign c_i = sub ? ~cin : cin;
         assign s_n = slice[CHUNK-1:0];
      end else begin : g_link
         assign v_i = g_st[k-1].v_q;
         assign a_i = g_st[k-1].g_fwd.a_q;
         assign b_i = g_st[k-1].g_fwd.b_q;
         assign c_i = g_st[k-1].c_q;
         assign s_n = {slice[CHUNK-1:0], g_st[k-1].s_q};
      end

      assign slice = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, c_i};

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (en) begin
            v_q <= v_i;
            if (v_i) begin
               c_q <= slice[CHUNK];
               s_q <= s_n;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:LO+CHUNK] a_q;
         logic [WIDTH-1:LO+CHUNK] b_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en && v_i) begin
               a_q <= a_i[WIDTH-1:LO+CHUNK];
               b_q <= b_i[WIDTH-1:LO+CHUNK];
            end
         end
      end else begin : g_last
         logic ovf_d;
         logic zero_d;
         logic ovf_q;
         logic zero_q;

         // The last slice holds the sign bits, so the flags are formed here
         assign ovf_d  = (a_i[MSB] == b_i[MSB]) && (slice[CHUNK-1] != a_i[MSB]);
         assign zero_d = (s_n == '0);

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (en && v_i) begin
               ovf_q  <= ovf_d;
               zero_q <= zero_d;
            end
         end
      end
   end

   assign out_valid = g_st[STAGES-1].v_q;
   assign f         = g_st[STAGES-1].s_q;
   assign cout      = g_st[STAGES-1].c_q;
   assign ovf       = g_st[STAGES-1].g_last.ovf_q;
   assign zero      = g_st[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed steps on the 16/4 build with a result queue, plus
// random ops on the 4/4 and 8/1 builds against an arithmetic reference model.
module tb_pipelined_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 16-bit, 4 stages
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
   logic [15:0] a, b, f;
   // 4-bit, 1 stage
   logic       iv4, ir4, cin4, sub4, ov4, co4, of4, z4;
   logic [3:0] a4, b4, f4;
   // 8-bit, 8 stages
   logic       iv8, ir8, cin8, sub8, ov8, co8, of8, z8;
   logic [7:0] a8, b8, f8;

   pipelined_adder u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .f(f),
      .cout(cout), .ovf(ovf), .zero(zero));

   pipelined_adder #(.WIDTH(4), .CHUNK(4)) u_cfg4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(1'b1), .f(f4),
      .cout(co4), .ovf(of4), .zero(z4));

   pipelined_adder #(.WIDTH(8), .CHUNK(1)) u_cfg8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(1'b1), .f(f8),
      .cout(co8), .ovf(of8), .zero(z8));

   // Expected entries: {f zero-extended to 16 bits, cout, ovf, zero}
   logic [18:0] exp_q[$];
   logic [18:0] exp4_q[$];
   logic [18:0] exp8_q[$];
   int          t4_q[$];
   int          t8_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          rand_ready = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow
   function automatic logic [18:0] model(input int w, input int av, input int bv,
                                         input bit c, input bit s);
      int m, ru, sa, sb, rs, fv;
      bit co, ov;
      m  = 1 << w;
      ru = s ? av - bv - int'(c) : av + bv + int'(c);
      co = s ? (ru >= 0) : (ru >= m);
      fv = (ru + 2 * m) % m;
      sa = (av >= m / 2) ? av - m : av;
      sb = (bv >= m / 2) ? bv - m : bv;
      rs = s ? sa - sb - int'(c) : sa + sb + int'(c);
      ov = (rs >= m / 2) || (rs < -(m / 2));
      return {fv[15:0], co, ov, (fv == 0)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
   endtask

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input logic sv, input logic [18:0] ev);
      bit acc;
      int n;
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
      n = 0;
      do begin
         acc = in_ready;
         if (acc) exp_q.push_back(ev);
         step();
         n++;
      end while (!acc && n < 50);
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         step();
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Main scoreboard: pops at the edge where a result transfers out
   bit          prev_stall = 1'b0;
   logic [18:0] prev_out;
   logic [18:0] got;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("in_ready_rule", 32'(in_ready), 32'(out_ready || !out_valid));
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'({f, cout, ovf, zero}), 32'(prev_out));
         end
         if (out_valid && out_ready) begin
            check("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               got = exp_q.pop_front();
               check("result", 32'({f, cout, ovf, zero}), 32'(got));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {f, cout, ovf, zero};
      end
   end

   always @(negedge clk) begin
      if (!rst && ov4) begin
         check("cfg4_expected", 32'(exp4_q.size() > 0), 32'd1);
         if (exp4_q.size() > 0) begin
            check("cfg4_result", 32'({12'h000, f4, co4, of4, z4}), 32'(exp4_q.pop_front()));
            check("cfg4_latency", cyc - t4_q.pop_front(), 1);
         end
      end
      if (!rst && ov8) begin
         check("cfg8_expected", 32'(exp8_q.size() > 0), 32'd1);
         if (exp8_q.size() > 0) begin
            check("cfg8_result", 32'({8'h00, f8, co8, of8, z8}), 32'(exp8_q.pop_front()));
            check("cfg8_latency", cyc - t8_q.pop_front(), 8);
         end
      end
   end

   initial begin
      int av, bv;
      bit cv, sv;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_flags", 32'({f, cout, ovf, zero}), 32'd0);
      check("reset_cfg_valid", 32'({ov4, ov8}), 32'd0);
      rst = 1'b0;
      #1;

      // Two consecutive ops; first result after four edges
      send(16'h0001, 16'h000A, 1'b0, 1'b0, {16'h000B, 3'b000});
      send(16'h0001, 16'h000A, 1'b1, 1'b0, {16'h000C, 3'b000});
      step();
      check("latency_not_early", 32'(out_valid), 32'd0);
      step();
      check("latency_4", 32'(out_valid), 32'd1);
      check("first_f", 32'(f), 32'h000B);
      step();
      check("second_f", 32'(f), 32'h000C);
      drain();

      // Carry across all slices, signed overflow, subtraction
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 3'b101});
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 3'b010});
      send(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 3'b000});
      send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 3'b110});
      drain();

      // Back-to-back ops under random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         av = int'($urandom_range(0, 65535));
         bv = int'($urandom_range(0, 65535));
         cv = 1'($urandom_range(0, 1));
         sv = 1'($urandom_range(0, 1));
         send(av[15:0], bv[15:0], cv, sv, model(16, av, bv, cv, sv));
      end
      drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      #1;

      // Reset with three ops in flight: none may emerge
      send(16'h1111, 16'h2222, 1'b0, 1'b0, {16'h3333, 3'b000});
      send(16'h0F0F, 16'h0101, 1'b1, 1'b0, {16'h1011, 3'b000});
      send(16'h4000, 16'h4000, 1'b0, 1'b0, {16'h8000, 3'b010});
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_flags", 32'({f, cout, ovf, zero}), 32'd0);
      rst = 1'b0;
      #1;
      repeat (6) step();
      check("flush_nothing_emerged", 32'(out_valid), 32'd0);
      send(16'h1234, 16'h1111, 1'b1, 1'b1, {16'h0122, 3'b100});
      drain();

      // Random ops on the single-stage and bit-serial builds
      for (int i = 0; i < 1000; i++) begin
         av = int'($urandom_range(0, 15));
         bv = int'($urandom_range(0, 15));
         cv = 1'($urandom_range(0, 1));
         sv = 1'($urandom_range(0, 1));
         iv4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv; sub4 = sv;
         exp4_q.push_back(model(4, av, bv, cv, sv));
         t4_q.push_back(cyc);
         av = int'($urandom_range(0, 255));
         bv = int'($urandom_range(0, 255));
         cv = 1'($urandom_range(0, 1));
         sv = 1'($urandom_range(0, 1));
         iv8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; sub8 = sv;
         exp8_q.push_back(model(8, av, bv, cv, sv));
         t8_q.push_back(cyc);
         if (i == 0) check("cfg_in_ready", 32'({ir4, ir8}), 32'd3);
         step();
      end
      iv4 = 1'b0;
      iv8 = 1'b0;
      repeat (12) step();
      check("cfg4_drained", exp4_q.size(), 0);
      check("cfg8_drained", exp8_q.size(), 0);
      check("main_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
